sha256_round_ctrl: RTL
======================

Name: sha256_round_ctrl

Overview:
Sequencer for the single-round SHA-256 compression datapath (round instance plus K-constant ROM). It accepts one 512-bit message block and a 256-bit chaining value, then drives the round datapath for 64 consecutive cycles while generating the message schedule W_t on the fly. It performs the final word-wise feed-forward addition and presents the 256-bit digest on a valid/ready handshake. Multi-block messages are chained externally by feeding each digest back as i_hash_in.

Parameters:
BLK_SIZE, 256, hash/working-state width (8 words)
WRD_SIZE, 32, word width; all arithmetic is mod 2^WRD_SIZE
MSG_SIZE, 512, message block width (16 words)
NUM_ROUNDS, 64, rounds per block; round counter is 6 bits

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
i_blk_valid  input  1  message block and chaining value are valid
o_blk_ready  output  1  controller can accept a block (IDLE only)
i_blk  input  MSG_SIZE  message block; word 0 = i_blk[511:480] (big-endian)
i_hash_in  input  BLK_SIZE  chaining value H; word a = [255:224]
o_round_en  output  1  enable to round datapath
o_round_addr  output  6  K-ROM address = current round index t
o_round_state  output  BLK_SIZE  working state presented to round (i_pre_blck_hash)
o_round_msg  output  WRD_SIZE  schedule word W_t presented to round
i_round_hash  input  BLK_SIZE  registered round output (o_hash)
o_busy  output  1  high in ROUND or FINAL
o_dig_valid  output  1  digest valid
i_dig_ready  input  1  digest consumer ready
o_digest  output  BLK_SIZE  H + final working state

Behaviour:
- Reset (async, any state, including mid-block): state IDLE; t=0; schedule window, latched H and o_digest all zero; o_blk_ready=1; o_round_en=0; o_busy=0; o_dig_valid=0; o_round_addr=0.
- The K ROM is combinational; the round datapath registers its output one cycle after o_round_en.
- States: IDLE -> ROUND -> FINAL -> DONE -> IDLE.
- IDLE:
  - o_blk_ready=1.
  - On i_blk_valid&o_blk_ready: latch i_hash_in into H_reg; load window w[0..15] = i_blk words 0..15; t=0; go to ROUND.
- ROUND:
  - o_round_en=1; o_round_addr=t; o_round_msg=w[0].
  - o_round_state = H_reg when t==0, else i_round_hash.
  - Each cycle: shift w[i]<=w[i+1] for i=0..14; w[15] <= s1(w[14]) + w[9] + s0(w[1]) + w[0].
    - s0(x) = ROTR7 ^ ROTR18 ^ SHR3.
    - s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - t increments each cycle. At t==63, go to FINAL; t wraps to 0.
  - No stall: exactly 64 consecutive enabled cycles per block.
- FINAL (1 cycle):
  - o_round_en=0.
  - o_digest <= per-word H_reg[i] + i_round_hash[i] mod 2^32, no carry between words.
  - Go to DONE.
- DONE:
  - o_dig_valid=1; o_digest held stable until i_dig_ready.
  - On the handshake: o_dig_valid=0 next cycle; go to IDLE.
  - o_blk_ready=0 in DONE; a new block is accepted no earlier than the cycle after digest handoff.
- i_blk_valid during ROUND/FINAL/DONE is ignored (not latched). i_blk and i_hash_in are sampled only on the accept edge.
- o_round_en=0 outside ROUND, so the round datapath holds o_hash.
- Latency: accept at edge N; o_round_en high cycles N+1..N+64; FINAL at N+65; o_dig_valid high from N+66. Minimum block-to-block period is 67 cycles.
- o_digest keeps its last value in IDLE; it is only cleared by reset.

Test Plan:
1. "abc": i_blk=0x61626380, 0 x 14 words, 0x00000018; i_hash_in=6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19 -> o_digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, o_dig_valid asserted exactly 66 cycles after accept.
2. Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", feeding digest 1 back as i_hash_in -> final digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
3. Schedule check on the "abc" block -> o_round_msg at t=16 is 61626380; at t=17 is 000f0000; at t=63 is 12b1edeb; o_round_addr steps 0..63 with o_round_en high for exactly 64 cycles.
4. Hold i_dig_ready=0 for 20 cycles with i_blk_valid=1 and a different block -> o_digest stable; o_blk_ready=0; no block accepted; after the i_dig_ready pulse, IDLE, then the new block is accepted the next cycle.
5. Assert reset_n=0 at round t=30, release, then send "abc" -> all outputs zero during reset; o_blk_ready=1 after release; correct digest as in scenario 1.
6. Pulse i_blk_valid during ROUND with garbage data -> ignored; digest of the in-flight block unchanged.

Source files
------------

// File: rtl/sha256_round_ctrl.sv
// -----------------------------------------------------------------------------
// sha256_round_ctrl
//
// Sequencer for a single-round SHA-256 compression datapath (one round
// instance plus a combinational K-constant ROM). A 512-bit message block and a
// 256-bit chaining value are accepted on a valid/ready handshake. The round
// datapath is then driven for NUM_ROUNDS consecutive cycles while the message
// schedule W_t is generated on the fly in a 16-word sliding window. After the
// last round, the controller adds the chaining value word-wise to the final
// working state. The digest is then presented on a second valid/ready
// handshake. Multi-block messages are chained externally.
//
// Ports
//   clk, reset_n     clock, asynchronous active-low reset
//   i_blk_valid      block + chaining value valid
//   o_blk_ready      controller idle and able to accept a block
//   i_blk            message block, word 0 in the top 32 bits
//   i_hash_in        chaining value H, word a in the top 32 bits
//   o_round_en       round datapath enable
//   o_round_addr     K-ROM address (current round index t)
//   o_round_state    working state fed to the round datapath
//   o_round_msg      schedule word W_t fed to the round datapath
//   i_round_hash     registered round datapath output
//   o_busy           block in flight (ROUND or FINAL)
//   o_dig_valid      digest valid
//   i_dig_ready      digest consumer ready
//   o_digest         H + final working state
// -----------------------------------------------------------------------------
module sha256_round_ctrl #(
  parameter int BLK_SIZE   = 256,
  parameter int WRD_SIZE   = 32,
  parameter int MSG_SIZE   = 512,
  parameter int NUM_ROUNDS = 64
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_blk_valid,
  output logic                          o_blk_ready,
  input  logic [MSG_SIZE-1:0]           i_blk,
  input  logic [BLK_SIZE-1:0]           i_hash_in,
  output logic                          o_round_en,
  output logic [$clog2(NUM_ROUNDS)-1:0] o_round_addr,
  output logic [BLK_SIZE-1:0]           o_round_state,
  output logic [WRD_SIZE-1:0]           o_round_msg,
  input  logic [BLK_SIZE-1:0]           i_round_hash,
  output logic                          o_busy,
  output logic                          o_dig_valid,
  input  logic                          i_dig_ready,
  output logic [BLK_SIZE-1:0]           o_digest
);

  localparam int CNT_W     = $clog2(NUM_ROUNDS);
  localparam int NUM_MSG_W = MSG_SIZE / WRD_SIZE;
  localparam int NUM_HSH_W = BLK_SIZE / WRD_SIZE;
  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  state_t                state_q;
  state_t                state_nxt;
  logic [CNT_W-1:0]      t_q;
  logic [BLK_SIZE-1:0]   h_q;
  logic [WRD_SIZE-1:0]   w_q [NUM_MSG_W];
  logic [WRD_SIZE-1:0]   w_next;
  logic                  accept;

  function automatic logic [WRD_SIZE-1:0] rotr(input logic [WRD_SIZE-1:0] x,
                                               input int n);
    return (x >> n) | (x << (WRD_SIZE - n));
  endfunction

  function automatic logic [WRD_SIZE-1:0] ssig0(input logic [WRD_SIZE-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WRD_SIZE-1:0] ssig1(input logic [WRD_SIZE-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // The window always holds W_t..W_t+15, so the new tail word is W_t+16.
  assign w_next = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];

  assign accept        = (state_q == S_IDLE) && i_blk_valid;
  assign o_round_addr  = t_q;
  assign o_round_msg   = w_q[0];
  // The first round starts from the chaining value. Later rounds start from
  // the registered output of the previous round.
  assign o_round_state = (t_q == '0) ? h_q : i_round_hash;

  // NOTE: every output is given a default before the case statement, so no
  // path leaves a signal unassigned and no latch can be inferred.
  always_comb begin
    state_nxt   = state_q;
    o_blk_ready = 1'b0;
    o_round_en  = 1'b0;
    o_busy      = 1'b0;
    o_dig_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        o_blk_ready = 1'b1;
        if (i_blk_valid) state_nxt = S_ROUND;
      end
      S_ROUND: begin
        o_round_en = 1'b1;
        o_busy     = 1'b1;
        if (t_q == LAST_ROUND) state_nxt = S_FINAL;
      end
      S_FINAL: begin
        o_busy    = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        o_dig_valid = 1'b1;
        if (i_dig_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments, so every register
  // samples the pre-edge values (the window shift relies on this).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_nxt;
  end

  // NOTE: the schedule window is reset along with the other registers because
  // w_q[0] is visible on o_round_msg and must read zero out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_q      <= '0;
      h_q      <= '0;
      o_digest <= '0;
      for (int i = 0; i < NUM_MSG_W; i++) w_q[i] <= '0;
    end else begin
      if (accept) begin
        t_q <= '0;
        h_q <= i_hash_in;
        for (int i = 0; i < NUM_MSG_W; i++)
          w_q[i] <= i_blk[MSG_SIZE-1-i*WRD_SIZE -: WRD_SIZE];
      end else if (state_q == S_ROUND) begin
        t_q <= (t_q == LAST_ROUND) ? '0 : t_q + 1'b1;
        for (int i = 0; i < NUM_MSG_W - 1; i++) w_q[i] <= w_q[i+1];
        w_q[NUM_MSG_W-1] <= w_next;
      end

      // Feed-forward: independent mod-2^32 adds, no carry between words.
      if (state_q == S_FINAL) begin
        for (int i = 0; i < NUM_HSH_W; i++)
          o_digest[BLK_SIZE-1-i*WRD_SIZE -: WRD_SIZE] <=
            h_q[BLK_SIZE-1-i*WRD_SIZE -: WRD_SIZE] +
            i_round_hash[BLK_SIZE-1-i*WRD_SIZE -: WRD_SIZE];
      end
    end
  end

endmodule
